// File: rtl/gain_amp_pipe.sv
// Three-stage signed gain stage: per-channel fixed-point gain, round-half-up, output tagged with channel.
// Define GAIN_AMP_SAT_EN to clamp out-of-range results (sat_o flags it); otherwise results wrap and sat_o is 0.
module gain_amp_pipe #(
  parameter int DATA_W   = 16,
  parameter int GAIN_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CH_W-1:0]   ch_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              gain_we_i,
  input  logic [CH_W-1:0]   gain_ch_i,
  input  logic [GAIN_W-1:0] gain_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sat_o
);

  localparam int P_W = DATA_W + GAIN_W;
  localparam int R_W = P_W + 1;
  localparam logic signed [GAIN_W-1:0] UNITY = GAIN_W'(1) << FRAC_W;

  logic                     en;
  logic signed [GAIN_W-1:0] gain_q [CHANNELS];
  logic signed [GAIN_W-1:0] gainSel;

  logic                     s1Valid_q;
  logic signed [DATA_W-1:0] s1Data_q;
  logic [CH_W-1:0]          s1Ch_q;
  logic signed [GAIN_W-1:0] s1Gain_q;

  logic                     s2Valid_q;
  logic signed [P_W-1:0]    s2Prod_q;
  logic signed [P_W-1:0]    s2Prod_d;
  logic [CH_W-1:0]          s2Ch_q;

  logic signed [R_W-1:0]    prodExt;
  logic signed [R_W-1:0]    rounded;
  logic [DATA_W-1:0]        outData_d;
  logic [DATA_W-1:0]        outData_q;
  logic [CH_W-1:0]          outCh_q;
  logic                     outValid_q;

  assign en      = ~outValid_q | ready_i;
  assign ready_o = en;

  // Out-of-range channels fall through to unity gain.
  always_comb begin
    gainSel = UNITY;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_i == CH_W'(c)) gainSel = gain_q[c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CHANNELS; c++) gain_q[c] <= UNITY;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (gain_we_i && gain_ch_i == CH_W'(c)) gain_q[c] <= gain_i;
      end
    end
  end

  assign s2Prod_d = P_W'(s1Data_q) * P_W'(s1Gain_q);
  assign prodExt  = {s2Prod_q[P_W-1], s2Prod_q};

  generate
    if (FRAC_W > 0) begin : g_round
      localparam logic signed [R_W-1:0] HALF = R_W'(1) << (FRAC_W - 1);
      logic signed [R_W-1:0] sumR;
      assign sumR    = prodExt + HALF;
      assign rounded = sumR >>> FRAC_W;
    end else begin : g_noround
      assign rounded = prodExt;
    end
  endgenerate

`ifdef GAIN_AMP_SAT_EN
  localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};
  logic overflow;
  logic outSat_q;

  // Result fits only if every bit above the output sign bit matches the sign.
  assign overflow  = rounded[R_W-1:DATA_W-1] != {(R_W-DATA_W+1){rounded[R_W-1]}};
  assign outData_d = overflow ? (rounded[R_W-1] ? MINV : MAXV) : rounded[DATA_W-1:0];
  assign sat_o     = outSat_q;
`else
  logic [R_W-DATA_W-1:0] unusedRoundedHi;
  assign unusedRoundedHi = rounded[R_W-1:DATA_W];
  assign outData_d       = rounded[DATA_W-1:0];
  assign sat_o           = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1Valid_q  <= 1'b0;
      s1Data_q   <= '0;
      s1Ch_q     <= '0;
      s1Gain_q   <= '0;
      s2Valid_q  <= 1'b0;
      s2Prod_q   <= '0;
      s2Ch_q     <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outCh_q    <= '0;
`ifdef GAIN_AMP_SAT_EN
      outSat_q   <= 1'b0;
`endif
    end else if (en) begin
      s1Valid_q  <= valid_i;
      s1Data_q   <= data_i;
      s1Ch_q     <= ch_i;
      s1Gain_q   <= gainSel;
      s2Valid_q  <= s1Valid_q;
      s2Prod_q   <= s2Prod_d;
      s2Ch_q     <= s1Ch_q;
      outValid_q <= s2Valid_q;
      outData_q  <= outData_d;
      outCh_q    <= s2Ch_q;
`ifdef GAIN_AMP_SAT_EN
      outSat_q   <= overflow;
`endif
    end
  end

  assign data_o  = outData_q;
  assign ch_o    = outCh_q;
  assign valid_o = outValid_q;

endmodule

// File: tb/tb_gain_amp_pipe.sv
// Directed bench for gain_amp_pipe: vector table plus hand-written stall, gain-write and reset sequences.
module tb_gain_amp_pipe;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic signed [15:0] data_i;
  logic [1:0]         ch_i;
  logic               valid_i;
  logic               ready_o;
  logic               gain_we_i;
  logic [1:0]         gain_ch_i;
  logic [15:0]        gain_i;
  logic signed [15:0] data_o;
  logic [1:0]         ch_o;
  logic               valid_o;
  logic               ready_i;
  logic               sat_o;

  typedef struct {
    int data;
    int ch;
    int expData;
    int expSat;
  } vec_t;

  typedef struct {
    int data;
    int ch;
    int sat;
  } exp_t;

  vec_t vecs [6];
  exp_t expQ [$];
  int   errors = 0;
  int   checks = 0;

  gain_amp_pipe dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .data_i    (data_i),
    .ch_i      (ch_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .gain_we_i (gain_we_i),
    .gain_ch_i (gain_ch_i),
    .gain_i    (gain_i),
    .data_o    (data_o),
    .ch_o      (ch_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .sat_o     (sat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one sample and returns 1ns after the edge that accepted it.
  task automatic applyStimulus(input int data, input int ch, input int expData,
                               input int expSat, input bit track);
    bit   acc = 1'b0;
    exp_t e;
    data_i  = 16'(data);
    ch_i    = 2'(ch);
    valid_i = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    if (!acc) checkOutput("acceptTimeout", 0, 1);
    else if (track) begin
      e.data = expData;
      e.ch   = ch;
      e.sat  = expSat;
      expQ.push_back(e);
    end
  endtask

  task automatic writeGain(input int ch, input int g);
    gain_we_i = 1'b1;
    gain_ch_i = 2'(ch);
    gain_i    = 16'(g);
    @(posedge clk_i);
    #1;
    gain_we_i = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 60 && expQ.size() != 0; i++) @(posedge clk_i);
    #1;
    checkOutput("drain", expQ.size(), 0);
  endtask

  // Output scoreboard: every handshake must match the next expected sample in order.
  always @(negedge clk_i) begin
    if (rst_n_i && valid_o && ready_i) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedOutput", int'(data_o), 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("data_o", int'(data_o), e.data);
        checkOutput("ch_o", int'(ch_o), e.ch);
        checkOutput("sat_o", int'(sat_o), e.sat);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1000, 0, 1000, 0};
    vecs[1] = '{1000, 2, 2000, 0};
    vecs[2] = '{3, 3, 2, 0};
    vecs[3] = '{-3, 3, -1, 0};
`ifdef GAIN_AMP_SAT_EN
    vecs[4] = '{20000, 1, 32767, 1};
    vecs[5] = '{-20000, 1, -32768, 1};
`else
    vecs[4] = '{20000, 1, -25536, 0};
    vecs[5] = '{-20000, 1, 25536, 0};
`endif

    rst_n_i   = 1'b0;
    data_i    = '0;
    ch_i      = '0;
    valid_i   = 1'b0;
    gain_we_i = 1'b0;
    gain_ch_i = '0;
    gain_i    = '0;
    ready_i   = 1'b1;
    #12;
    checkOutput("resetValid", int'(valid_o), 0);
    checkOutput("resetData", int'(data_o), 0);
    checkOutput("resetSat", int'(sat_o), 0);
    checkOutput("resetReady", int'(ready_o), 1);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] unity gain and latency");
    applyStimulus(vecs[0].data, vecs[0].ch, vecs[0].expData, vecs[0].expSat, 1'b1);
    @(posedge clk_i);
    #1;
    checkOutput("latencyEdge2", int'(valid_o), 0);
    @(posedge clk_i);
    #1;
    checkOutput("latencyEdge3", int'(valid_o), 1);
    waitDrain();

    $display("[TB] programmed gains, rounding and range limits");
    writeGain(2, 16'h0200);
    writeGain(3, 16'h0080);
    writeGain(1, 16'h0200);
    for (int i = 1; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].ch, vecs[i].expData, vecs[i].expSat, 1'b1);
    end
    waitDrain();

    $display("[TB] backpressure stall");
    fork
      begin
        for (int k = 1; k <= 6; k++) applyStimulus(k, 2, 2 * k, 0, 1'b1);
      end
      begin
        repeat (4) @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        repeat (4) begin
          @(negedge clk_i);
          checkOutput("stallReady", int'(ready_o), 0);
          checkOutput("stallValid", int'(valid_o), 1);
          checkOutput("stallData", int'(data_o), 4);
          checkOutput("stallCh", int'(ch_o), 2);
        end
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] gain write on acceptance edge");
    gain_we_i = 1'b1;
    gain_ch_i = 2'd0;
    gain_i    = 16'h0300;
    applyStimulus(10, 0, 10, 0, 1'b1);
    gain_we_i = 1'b0;
    applyStimulus(10, 0, 30, 0, 1'b1);
    waitDrain();

    $display("[TB] asynchronous reset with samples in flight");
    applyStimulus(7, 2, 14, 0, 1'b0);
    applyStimulus(8, 2, 16, 0, 1'b0);
    applyStimulus(9, 2, 18, 0, 1'b0);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("midResetValid", int'(valid_o), 0);
    checkOutput("midResetData", int'(data_o), 0);
    checkOutput("midResetSat", int'(sat_o), 0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    repeat (6) begin
      @(negedge clk_i);
      checkOutput("noStaleOutput", int'(valid_o), 0);
    end
    @(posedge clk_i);
    #1;
    applyStimulus(100, 2, 100, 0, 1'b1);
    applyStimulus(3, 3, 3, 0, 1'b1);
    waitDrain();

    repeat (2) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
